// File: rtl/axi4_wr_slave_ctrl.sv
// axi4_wr_slave_ctrl: AXI4 write-channel slave (AW/W/B) for a word-addressed memory.
// Accepts INCR bursts of full-width beats. Each burst is range-checked once, when its
// address is accepted. Out-of-range bursts are drained without writing and answered with SLVERR.
// The burst length is set by AWLEN. A WLAST that disagrees with the beat count is recorded
// and reported as SLVERR; the memory writes still go ahead.
// Optional feature macro: AXI_WSTRB_EN (forward WSTRB to the memory and skip all-zero-strobe beats).
module axi4_wr_slave_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  output logic                    mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);

  localparam int NB  = DATA_WIDTH / 8;
  localparam int NBL = $clog2(NB);
  localparam int MAW = $clog2(MEM_DEPTH);

  // axi_resp_e encodings; EXOKAY is never produced because exclusive access is unsupported
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           awready_q, awready_d;
  logic           wready_q, wready_d;
  logic           bvalid_q, bvalid_d;
  logic [1:0]     bresp_q, bresp_d;
  logic [MAW-1:0] wptr_q, wptr_d;
  logic [7:0]     len_q, len_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           inlimit_q, inlimit_d;
  logic           err_q, err_d;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  last_beat;
  logic                  err_next;
  logic [ADDR_WIDTH:0]   end_word;
  logic                  beat_writes;

  // One bit wider than the address so that start_word + AWLEN cannot wrap
  assign end_word = (ADDR_WIDTH+1)'(AWADDR >> NBL) + (ADDR_WIDTH+1)'(AWLEN);

  assign aw_hs     = AWVALID && awready_q;
  assign w_hs      = WVALID && wready_q;
  assign last_beat = (cnt_q == len_q);
  assign err_next  = err_q || (WLAST != last_beat);

`ifdef AXI_WSTRB_EN
  assign beat_writes = |WSTRB;
  assign mem_wstrb   = WSTRB;
`else
  logic unused_wstrb;
  assign unused_wstrb = ^WSTRB;
  assign beat_writes  = 1'b1;
  assign mem_wstrb    = {NB{1'b1}};
`endif

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign mem_we    = w_hs && inlimit_q && beat_writes;
  assign mem_addr  = wptr_q;
  assign mem_wdata = WDATA;

  // Next-state logic for the IDLE -> DATA -> RESP burst sequence
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    wptr_d    = wptr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    inlimit_d = inlimit_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        awready_d = 1'b1;
        if (aw_hs) begin
          state_d   = ST_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wptr_d    = MAW'(AWADDR >> NBL);
          len_d     = AWLEN;
          cnt_d     = 8'd0;
          inlimit_d = (end_word < (ADDR_WIDTH+1)'(MEM_DEPTH));
          err_d     = 1'b0;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          cnt_d  = cnt_q + 8'd1;
          wptr_d = wptr_q + MAW'(1);
          err_d  = err_next;
          if (last_beat) begin
            state_d  = ST_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_next || !inlimit_q) ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      ST_RESP: begin
        if (bvalid_q && BREADY) begin
          state_d   = ST_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awready_d = 1'b0;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
        bresp_d   = RESP_OKAY;
      end
    endcase
  end

  // State registers; reset drops any partial burst without a response
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      wptr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      inlimit_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      wptr_q    <= wptr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      inlimit_q <= inlimit_d;
      err_q     <= err_d;
    end
  end

endmodule
